// File: rtl/conv_core.sv
// Streaming FIR: delay line x APB-loaded coefficient bank, registered multiply and
// adder tree, output aligned with a delayed copy of the input. CONV_CORE_SATURATE_EN clamps the result.
module conv_core #(
  parameter int CONV_CORE_DEPTH   = 256,
  parameter int DATA_BITWIDTH     = 16,
  parameter int OUTPUT_SHIFT_BITS = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_BITWIDTH-1:0] data_in,
  input  logic                     data_enable,
  output logic [DATA_BITWIDTH-1:0] data_pp_out,
  output logic [DATA_BITWIDTH-1:0] data_res_out,
  input  logic                     p_sel,
  input  logic                     p_ce,
  input  logic                     p_we,
  input  logic [3:0]               p_strb,
  input  logic [31:0]              p_addr,
  input  logic [31:0]              p_wdata,
  output logic                     p_rdy,
  output logic [31:0]              p_rdata
);
  localparam int DW    = DATA_BITWIDTH;
  localparam int LOG2  = $clog2(CONV_CORE_DEPTH);
  localparam int ACC_W = 2 * DW + LOG2;
  localparam int NODES = 2 * CONV_CORE_DEPTH - 1;
  localparam int LAT   = LOG2 + 3;

  logic [31:0]             coef_q [CONV_CORE_DEPTH];
  logic signed [DW-1:0]    tap_q  [CONV_CORE_DEPTH];
  logic signed [2*DW-1:0]  prod_d [CONV_CORE_DEPTH];
  // Heap-ordered tree: node n sums children 2n+1/2n+2, leaves are the products.
  logic signed [ACC_W-1:0] node_q [NODES];
  logic signed [DW-1:0]    red_d, red_q;
  logic [DW-1:0]           res_q;
  logic [DW-1:0]           pp_q   [LAT-1];
  logic [DW-1:0]           pp_out_q;

  logic                    addr_ok;
  logic [LOG2-1:0]         idx;

  assign addr_ok = (p_addr < 32'(CONV_CORE_DEPTH));
  assign idx     = p_addr[LOG2-1:0];
  assign p_rdy   = p_sel & p_ce;
  assign p_rdata = addr_ok ? coef_q[idx] : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CONV_CORE_DEPTH; k++) coef_q[k] <= '0;
    end else if (p_sel && p_ce && p_we && addr_ok) begin
      for (int b = 0; b < 4; b++)
        if (p_strb[b]) coef_q[idx][8*b +: 8] <= p_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CONV_CORE_DEPTH; k++) tap_q[k] <= '0;
    end else if (data_enable) begin
      tap_q[0] <= {~data_in[DW-1], data_in[DW-2:0]};
      for (int k = 1; k < CONV_CORE_DEPTH; k++) tap_q[k] <= tap_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < CONV_CORE_DEPTH; k++)
      prod_d[k] = (2*DW)'(tap_q[k]) * (2*DW)'($signed(coef_q[k][DW-1:0]));
  end

`ifdef CONV_CORE_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [ACC_W-1:0] sh;
  assign sh = node_q[0] >>> OUTPUT_SHIFT_BITS;
  always_comb begin
    red_d = sh[DW-1:0];
    if (sh > SAT_MAX)      red_d = SAT_MAX[DW-1:0];
    else if (sh < SAT_MIN) red_d = SAT_MIN[DW-1:0];
  end
`else
  assign red_d = DW'(node_q[0] >>> OUTPUT_SHIFT_BITS);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NODES; n++) node_q[n] <= '0;
      for (int i = 0; i < LAT-1; i++) pp_q[i] <= '0;
      red_q    <= '0;
      res_q    <= '0;
      pp_out_q <= '0;
    end else begin
      for (int k = 0; k < CONV_CORE_DEPTH; k++)
        node_q[CONV_CORE_DEPTH-1+k] <= ACC_W'(prod_d[k]);
      for (int n = 0; n < CONV_CORE_DEPTH-1; n++)
        node_q[n] <= node_q[2*n+1] + node_q[2*n+2];
      red_q <= red_d;
      res_q <= {~red_q[DW-1], red_q[DW-2:0]};
      // Sample copy travels the same number of stages as the arithmetic path.
      pp_q[0] <= tap_q[0];
      for (int i = 1; i < LAT-1; i++) pp_q[i] <= pp_q[i-1];
      pp_out_q <= {~pp_q[LAT-2][DW-1], pp_q[LAT-2][DW-2:0]};
    end
  end

  assign data_res_out = res_q;
  assign data_pp_out  = pp_out_q;
endmodule

// File: tb/tb_conv_core.sv
// Bench for conv_core: randomized streaming and bus traffic checked against a
// per-edge behavioural model (dot product over a sample history, delayed by L).
module tb_conv_core;
  localparam int DEPTH = 256;
  localparam int DW    = 16;
  localparam int SHIFT = 12;
  localparam int L     = $clog2(DEPTH) + 3;
`ifdef CONV_CORE_SATURATE_EN
  localparam logic [15:0] OVF_RES = 16'hFFFF;
`else
  localparam logic [15:0] OVF_RES = 16'h7FE0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_enable = 1'b0;
  logic [15:0] data_pp_out, data_res_out;
  logic        p_sel = 1'b0, p_ce = 1'b0, p_we = 1'b0;
  logic [3:0]  p_strb = '0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic        p_rdy;
  logic [31:0] p_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0]        mcoef [DEPTH];
  logic signed [15:0] mtap  [DEPTH];
  logic [15:0]        q_res [$];
  logic [15:0]        q_pp  [$];
  logic [15:0]        want_res, want_pp;
  int                 ph = 0;

  conv_core #(.CONV_CORE_DEPTH(DEPTH), .DATA_BITWIDTH(DW), .OUTPUT_SHIFT_BITS(SHIFT)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_enable(data_enable),
    .data_pp_out(data_pp_out), .data_res_out(data_res_out),
    .p_sel(p_sel), .p_ce(p_ce), .p_we(p_we), .p_strb(p_strb), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_rdy(p_rdy), .p_rdata(p_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] model_res();
    longint acc = 0;
    for (int k = 0; k < DEPTH; k++)
      acc += longint'(mtap[k]) * longint'($signed(mcoef[k][15:0]));
    acc = acc >>> SHIFT;
`ifdef CONV_CORE_SATURATE_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    return acc[15:0] ^ 16'h8000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      mtap[k]  = '0;
      mcoef[k] = '0;
    end
    q_res.delete();
    q_pp.delete();
    for (int i = 0; i < L; i++) begin
      q_res.push_back(16'h8000);
      q_pp.push_back(16'h8000);
    end
    want_res = '0;
    want_pp  = '0;
  endtask

  // Called just after a rising edge, while inputs still hold their pre-edge values.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      if (p_sel && p_ce && p_we && p_addr < DEPTH)
        for (int b = 0; b < 4; b++)
          if (p_strb[b]) mcoef[p_addr][8*b +: 8] = p_wdata[8*b +: 8];
      if (data_enable) begin
        for (int k = DEPTH-1; k > 0; k--) mtap[k] = mtap[k-1];
        mtap[0] = $signed(data_in ^ 16'h8000);
      end
      want_res = q_res.pop_front();
      want_pp  = q_pp.pop_front();
      q_res.push_back(model_res());
      q_pp.push_back(16'(mtap[0]) ^ 16'h8000);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("res", {16'h0, data_res_out}, {16'h0, want_res});
    chk("pp",  {16'h0, data_pp_out},  {16'h0, want_pp});
  endtask

  task automatic bus_idle();
    p_sel = 1'b0; p_ce = 1'b0; p_we = 1'b0; p_strb = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    p_sel = 1'b1; p_ce = 1'b1; p_we = 1'b1; p_addr = a; p_wdata = d; p_strb = s;
    #1;
    chk("wr_rdy", {31'h0, p_rdy}, 32'h1);
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] want);
    p_sel = 1'b1; p_ce = 1'b1; p_we = 1'b0; p_addr = a;
    #1;
    chk("rd_rdy", {31'h0, p_rdy}, 32'h1);
    chk("rdata", p_rdata, want);
    tick();
    bus_idle();
  endtask

  task automatic stream(input int n, input int en_pct, input bit sine, input bit busr);
    for (int i = 0; i < n; i++) begin
      if (sine) begin
        data_in = 16'(32768 + int'(12000.0 * $sin(2.0 * 3.14159265 * ph / 37.0)));
        ph++;
      end else begin
        data_in = 16'($urandom);
      end
      data_enable = ($urandom_range(99) < en_pct);
      if (busr && $urandom_range(7) == 0) begin
        p_sel = 1'b1; p_ce = 1'b1; p_we = 1'b1;
        p_addr = $urandom_range(DEPTH + 7); p_wdata = $urandom; p_strb = 4'($urandom);
      end else begin
        bus_idle();
      end
      tick();
    end
    bus_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_res", {16'h0, data_res_out}, 32'h0);
    chk("rst_pp",  {16'h0, data_pp_out},  32'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int lat_r, lat_p;
    data_in = 16'h1234; data_enable = 1'b1; p_addr = '0;
    #2;
    do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    chk("rst_rdata0", p_rdata, 32'h0);
    rst = 1'b0;

    // Register access, including an out-of-range write.
    data_enable = 1'b0;
    bus_write(32'd5, 32'hDEADBEEF, 4'b0011);
    bus_read(32'd5, 32'h0000BEEF);
    bus_write(32'd300, 32'hCAFEF00D, 4'b1111);
    bus_read(32'd300, 32'h0);

    // Random full coefficient bank with streaming alongside the loads.
    for (int k = 0; k < DEPTH; k++) begin
      data_in = 16'($urandom);
      data_enable = $urandom_range(1) == 1;
      bus_write(k, $urandom, 4'hF);
    end
    bus_read(32'd17, mcoef[17]);
    stream(200, 70, 1'b0, 1'b1);

    // Asynchronous reset in mid-cycle.
    @(posedge clk);
    model_edge();
    #4;
    do_reset();

    // Identity filter on a sine.
    bus_write(32'd0, 32'd4096, 4'hF);
    stream(60, 100, 1'b1, 1'b0);

    // Pure delay by 3 taps, with a 5-cycle freeze.
    bus_write(32'd0, 32'd0, 4'hF);
    bus_write(32'd3, 32'd4096, 4'hF);
    stream(30, 100, 1'b0, 1'b0);
    stream(5, 0, 1'b0, 1'b0);
    stream(20, 100, 1'b0, 1'b0);

    // Latency of a step from 0x8000 to 0x9000.
    do_reset();
    bus_write(32'd0, 32'd4096, 4'hF);
    data_in = 16'h8000; data_enable = 1'b1;
    repeat (20) tick();
    data_in = 16'h9000;
    tick();
    lat_r = -1; lat_p = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (lat_r < 0 && data_res_out !== 16'h8000) lat_r = i;
      if (lat_p < 0 && data_pp_out !== 16'h8000) lat_p = i;
      if (lat_r >= 0 && lat_p >= 0) break;
    end
    chk("lat_res", 32'(lat_r), 32'(L));
    chk("lat_pp",  32'(lat_p), 32'(L));
    chk("step_res", {16'h0, data_res_out}, 32'h9000);

    // Overflow with two full-scale taps.
    bus_write(32'd0, 32'h7FFF, 4'hF);
    bus_write(32'd1, 32'h7FFF, 4'hF);
    data_in = 16'hFFFF; data_enable = 1'b1;
    repeat (20) tick();
    chk("ovf_res", {16'h0, data_res_out}, {16'h0, OVF_RES});
    chk("ovf_pp",  {16'h0, data_pp_out},  32'hFFFF);

    // Random coefficients and traffic again to close.
    stream(150, 80, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_core.md
# conv_core

Streaming FIR convolution block. It keeps a CONV_CORE_DEPTH-tap sample delay line and a bank of coefficients that software loads over an APB-style register port. Each clock it produces the scaled dot product of taps and coefficients, plus a copy of the input delayed to line up with that result. It sits between the ADC-side sample stream and downstream filtering/analysis logic. Module name: conv_core.

## Interface
Parameters:
- CONV_CORE_DEPTH, 256: number of taps and coefficients; must be a power of two, at least 2.
- DATA_BITWIDTH, 16: sample width, which is also the coefficient width used in arithmetic.
- OUTPUT_SHIFT_BITS, 12: arithmetic right shift applied to the accumulated sum.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  DATA_BITWIDTH  input sample, offset-binary (0x8000 = zero for 16 bit).
- data_enable  in  1  sample-valid; shifts data_in into the delay line.
- data_pp_out  out  DATA_BITWIDTH  data_in delayed to align with data_res_out (offset-binary).
- data_res_out  out  DATA_BITWIDTH  filter result (offset-binary).
- p_sel  in  1  bus select.
- p_ce  in  1  bus access/enable phase.
- p_we  in  1  1 = write, 0 = read.
- p_strb  in  4  byte write enables for p_wdata.
- p_addr  in  32  coefficient word index (not byte address).
- p_wdata  in  32  write data.
- p_rdy  out  1  transfer complete.
- p_rdata  out  32  read data.

## Operation
- Coefficient bank: CONV_CORE_DEPTH registers, each 32 bits wide.
  - Arithmetic uses bits [DATA_BITWIDTH-1:0] of each register, interpreted as signed two's complement.
  - Coefficient k multiplies tap k. Tap 0 holds the newest sample.
- Bus write: on the edge where p_sel & p_ce & p_we are all high and p_addr < CONV_CORE_DEPTH, byte i of coefficient[p_addr] takes p_wdata byte i for each p_strb[i] = 1.
  - Writes to out-of-range addresses are ignored.
- Bus read: p_rdata = coefficient[p_addr] (combinational) when p_addr < CONV_CORE_DEPTH, otherwise 0.
- p_rdy = p_sel & p_ce (combinational). There are no wait states; every access completes in its first access-phase cycle.
- Input conversion: the MSB of data_in is inverted, giving a signed sample.
- Delay line: when data_enable = 1, tap[0] takes the converted sample and tap[k] takes tap[k-1]. When data_enable = 0, the delay line holds.
- Pipeline:
  - Stage M: each of the CONV_CORE_DEPTH products tap[k]*coef[k] is registered; products are signed, 2*DATA_BITWIDTH bits.
  - Reduction: a registered binary adder tree with log2(CONV_CORE_DEPTH) levels; the accumulator is 2*DATA_BITWIDTH + log2(CONV_CORE_DEPTH) bits signed.
  - Output stage: the sum is arithmetically shifted right by OUTPUT_SHIFT_BITS, reduced to DATA_BITWIDTH bits (see Configuration), MSB-inverted back to offset-binary, and registered.
- data_pp_out: tap[0] passed through a shift register of identical depth, then MSB-inverted back to offset-binary. The original sample and its filtered result therefore emerge on the same cycle.
- The arithmetic pipeline runs every clock regardless of data_enable.
- A coefficient write takes effect at the next Stage M capture. There is no atomic multi-coefficient update.

## Timing
- Latency L = log2(CONV_CORE_DEPTH) + 3 clocks, from the edge that captures data_in into tap[0] to the edge that updates data_res_out and data_pp_out. For depth 256, L = 11.
- Throughput: one sample per clock.
- Reset: all taps, pipeline registers and coefficients clear to 0. data_res_out and data_pp_out reset to 0 (raw register value, before any conversion). p_rdy and p_rdata follow their combinational definitions.
- Reset asserted mid-stream clears everything immediately. Outputs become valid L clocks after the first post-reset enabled sample; earlier outputs reflect zero taps and read 0x8000 once the pipeline has flushed.
- A bus write concurrent with streaming is legal.

## Configuration
- CONV_CORE_SATURATE_EN defined: the shifted sum is saturated to the signed DATA_BITWIDTH range [-2^(DW-1), 2^(DW-1)-1] before MSB inversion.
- CONV_CORE_SATURATE_EN undefined: the shifted sum is truncated to its low DATA_BITWIDTH bits (wrap-around).

## Test plan
- Reset: hold rst high, drive data_in = 0x1234 and data_enable = 1 -> data_res_out = 0, data_pp_out = 0, p_rdata for address 0 reads 0.
- Register access: write 0xDEADBEEF to address 5 with p_strb = 4'b0011 -> readback 0x0000BEEF, with p_rdy high during the access phase. A write to address 300 is ignored and reading it returns 0.
- Identity filter: coef[0] = 4096, all other coefficients 0, OUTPUT_SHIFT_BITS = 12, stream a sine with offset 0x8000 -> data_res_out equals data_pp_out on every cycle after L + 1 clocks.
- Delay tap: coef[3] = 4096, others 0 -> data_res_out equals data_pp_out from 3 enabled samples earlier. Dropping data_enable for 5 clocks freezes the relationship.
- Latency: all coefficients 0 except coef[0] = 4096, step data_in from 0x8000 to 0x9000 -> both outputs change exactly L = 11 clocks after the capturing edge.
- Overflow: coef[0] = coef[1] = 0x7FFF, data_in held at 0xFFFF -> 0xFFFF with CONV_CORE_SATURATE_EN defined; the wrapped value without it.
